output_port_arbiter: RTL and testbench

//  Wormhole output-port arbiter for the NoC router. Shares one output link among N_IN input

---
 rtl/output_port_arbiter_pkg.sv | 36 +++
 rtl/output_port_arbiter_rr_arbiter.sv | 39 +++
 rtl/output_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_output_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/output_port_arbiter_pkg.sv
// Shared flit-type codes, FSM state type and flit-type helpers for the output port arbiter.
// Optional build macro used elsewhere in this slice: ARB_STATS_EN.
`ifndef FLIT_LENGTH
`define FLIT_LENGTH 32
`endif

package output_port_arbiter_pkg;

   localparam int FLIT_LENGTH_DEF = `FLIT_LENGTH;

   localparam int FLIT_TYPE_W = 2;

   typedef enum logic [FLIT_TYPE_W-1:0] {
      FLIT_TYPE_BODY   = 2'b00,
      FLIT_TYPE_TAIL   = 2'b01,
      FLIT_TYPE_HEAD   = 2'b10,
      FLIT_TYPE_SINGLE = 2'b11
   } flit_type_e;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   // HEAD and SINGLE both open a packet; TAIL and SINGLE both close one.
   function automatic logic is_head_type(input logic [FLIT_TYPE_W-1:0] t);
      return t[1];
   endfunction

   function automatic logic is_tail_type(input logic [FLIT_TYPE_W-1:0] t);
      return t[0];
   endfunction

   localparam int STAT_W = 16;

endpackage

// File: rtl/output_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above ptr, else lowest overall.
module rr_arbiter #(
   parameter int N_IN  = 5,
   parameter int PTR_W = 3
) (
   input  logic [N_IN-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_IN-1:0]  grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             any
);

   logic [N_IN-1:0] hi_mask;
   logic [N_IN-1:0] hi_req;
   logic [N_IN-1:0] sel_req;

   genvar gi;
   generate
      for (gi = 0; gi < N_IN; gi++) begin : g_mask
         assign hi_mask[gi] = (PTR_W'(gi) >= ptr);
         assign grant[gi]   = any & (grant_idx == PTR_W'(gi));
      end
   endgenerate

   assign hi_req  = req & hi_mask;
   assign sel_req = (|hi_req) ? hi_req : req;
   assign any     = |req;

   // Scan downwards so the lowest set bit of sel_req wins.
   always_comb begin
      grant_idx = '0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (sel_req[i]) begin
            grant_idx = PTR_W'(i);
         end
      end
   end

endmodule

// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin grant on head flits, port locked until the tail.
// Build option: define ARB_STATS_EN to add saturating packet and stall counters.
module output_port_arbiter
   import output_port_arbiter_pkg::*;
#(
   parameter int N_IN   = 5,
   parameter int FLIT_W = FLIT_LENGTH_DEF,
   parameter int PTR_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_IN-1:0]          req_i,
   input  logic [N_IN-1:0]          empty_i,
   input  logic [N_IN*FLIT_W-1:0]   data_i,
   output logic [N_IN-1:0]          pop_o,
   input  logic                     full_i,
   output logic                     push_o,
   output logic [FLIT_W-1:0]        data_o,
   output logic [N_IN-1:0]          grant_o,
   output logic                     busy_o
`ifdef ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]        pkt_cnt_o,
   output logic [STAT_W-1:0]        stall_cnt_o
`endif
);

   arb_state_e       state_reg, state_next;
   logic [PTR_W-1:0] ptr_reg, ptr_next;
   logic [PTR_W-1:0] gidx_reg, gidx_next;
   logic [N_IN-1:0]  grant_reg, grant_next;

   logic [N_IN-1:0]  eligible;
   logic [N_IN-1:0]  arb_grant;
   logic [PTR_W-1:0] arb_idx;
   logic             arb_any;

   logic [FLIT_W-1:0] cur_flit;
   logic              cur_empty;
   logic              locked;
   logic              transfer;
   logic              tail_xfer;

   genvar gi;
   generate
      for (gi = 0; gi < N_IN; gi++) begin : g_elig
         assign eligible[gi] = req_i[gi] & ~empty_i[gi]
                             & is_head_type(data_i[gi*FLIT_W + FLIT_W - 1 -: FLIT_TYPE_W]);
      end
   endgenerate

   rr_arbiter #(
      .N_IN  (N_IN),
      .PTR_W (PTR_W)
   ) u_rr (
      .req       (eligible),
      .ptr       (ptr_reg),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any       (arb_any)
   );

   // Front flit and empty flag of the current owner.
   always_comb begin
      cur_flit  = '0;
      cur_empty = 1'b1;
      for (int k = 0; k < N_IN; k++) begin
         if (gidx_reg == PTR_W'(k)) begin
            cur_flit  = data_i[k*FLIT_W +: FLIT_W];
            cur_empty = empty_i[k];
         end
      end
   end

   assign locked    = (state_reg == ST_LOCKED);
   assign transfer  = locked & ~cur_empty & ~full_i & ~rst;
   assign tail_xfer = transfer & is_tail_type(cur_flit[FLIT_W-1 -: FLIT_TYPE_W]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         ptr_reg   <= '0;
         gidx_reg  <= '0;
         grant_reg <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         gidx_reg  <= gidx_next;
         grant_reg <= grant_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      gidx_next  = gidx_reg;
      grant_next = grant_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (arb_any) begin
               state_next = ST_LOCKED;
               gidx_next  = arb_idx;
               grant_next = arb_grant;
            end
         end
         ST_LOCKED: begin
            // The pointer only advances when a packet finishes, past its owner.
            if (tail_xfer) begin
               state_next = ST_IDLE;
               grant_next = '0;
               ptr_next   = (gidx_reg == PTR_W'(N_IN - 1)) ? '0 : gidx_reg + 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      pop_o   = transfer ? grant_reg : '0;
      push_o  = transfer;
      data_o  = locked ? cur_flit : '0;
      grant_o = grant_reg;
      busy_o  = locked;
   end

`ifdef ARB_STATS_EN
   logic [STAT_W-1:0] pkt_cnt_reg;
   logic [STAT_W-1:0] stall_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt_reg   <= '0;
         stall_cnt_reg <= '0;
      end else begin
         if (tail_xfer && (pkt_cnt_reg != '1)) begin
            pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
         end
         if (locked && !transfer && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         end
      end
   end

   assign pkt_cnt_o   = pkt_cnt_reg;
   assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: per-input FIFO models plus an expected-flit scoreboard.
module tb_output_port_arbiter;
   import output_port_arbiter_pkg::*;

   localparam int N  = 5;
   localparam int FW = 32;
   localparam int PW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req_i = '0;
   logic [N-1:0]    empty_i = '1;
   logic [N*FW-1:0] data_i = '0;
   logic [N-1:0]    pop_o;
   logic            full_i = 1'b0;
   logic            push_o;
   logic [FW-1:0]   data_o;
   logic [N-1:0]    grant_o;
   logic            busy_o;
`ifdef ARB_STATS_EN
   logic [15:0]     pkt_cnt;
   logic [15:0]     stall_cnt;
`endif

   output_port_arbiter #(.N_IN(N), .FLIT_W(FW), .PTR_W(PW)) dut (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req_i),
      .empty_i (empty_i),
      .data_i  (data_i),
      .pop_o   (pop_o),
      .full_i  (full_i),
      .push_o  (push_o),
      .data_o  (data_o),
      .grant_o (grant_o),
      .busy_o  (busy_o)
`ifdef ARB_STATS_EN
      ,
      .pkt_cnt_o   (pkt_cnt),
      .stall_cnt_o (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int            src;
      logic [FW-1:0] flit;
   } exp_t;

   logic [FW-1:0] inq [N][$];
   exp_t          sb [$];
   int            n_checks = 0;
   int            n_errors = 0;
   int            pkt_id = 0;
   logic          rst_r = 1'b0;
   logic          full_r = 1'b0;
   logic [N-1:0]  hide = '0;
   logic [N-1:0]  req_mask = '1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs at negedge, sample 1ns later, retire popped flits from the models.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      rst    = rst_r;
      full_i = full_r;
      for (int k = 0; k < N; k++) begin
         empty_i[k]          = (inq[k].size() == 0) | hide[k];
         data_i[k*FW +: FW]  = (inq[k].size() != 0) ? inq[k][0] : '0;
         req_i[k]            = req_mask[k] & (inq[k].size() != 0);
      end
      #1;
      check("push_vs_pop", 64'(push_o), 64'(|pop_o));
      check("pop_onehot0", 64'($onehot0(pop_o)), 64'd1);
      if (push_o) begin
         if (sb.size() == 0) begin
            check("unexpected_push", 64'(push_o), 64'd0);
         end else begin
            e = sb.pop_front();
            $display("xfer src=%0d flit=%h grant=%b", e.src, data_o, grant_o);
            check("data_o", 64'(data_o), 64'(e.flit));
            check("pop_src", 64'(pop_o), 64'(1 << e.src));
         end
      end
      for (int k = 0; k < N; k++) begin
         if (pop_o[k] && inq[k].size() != 0) void'(inq[k].pop_front());
      end
   endtask

   task automatic load_pkt(input int src, input int nfl);
      logic [1:0] t;
      exp_t       e;
      for (int i = 0; i < nfl; i++) begin
         if (nfl == 1)            t = FLIT_TYPE_SINGLE;
         else if (i == 0)         t = FLIT_TYPE_HEAD;
         else if (i == nfl - 1)   t = FLIT_TYPE_TAIL;
         else                     t = FLIT_TYPE_BODY;
         e.src  = src;
         e.flit = {t, 6'd0, 8'(src), 8'(pkt_id), 8'(i)};
         inq[src].push_back(e.flit);
         sb.push_back(e);
      end
      pkt_id++;
   endtask

   task automatic drain(input string tag, input int max_cyc, input int exp_n);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max_cyc) begin
         cycle();
         n++;
      end
      check({tag, "_cycles"}, 64'(n), 64'(exp_n));
   endtask

   task automatic do_reset();
      rst_r = 1'b1;
      cycle();
      check("rst_push", 64'(push_o), 64'd0);
      cycle();
      rst_r = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      cycle();
      check("rst_grant", 64'(grant_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_data", 64'(data_o), 64'd0);

      // 1: single requester, 3-flit packet
      load_pkt(0, 3);
      cycle();
      check("t1_bubble_push", 64'(push_o), 64'd0);
      drain("t1", 10, 3);
      cycle();
      check("t1_idle_busy", 64'(busy_o), 64'd0);
      check("t1_idle_grant", 64'(grant_o), 64'd0);

      // 2: all five inputs from reset, served 0..4, three cycles each
      do_reset();
      for (int k = 0; k < N; k++) load_pkt(k, 2);
      drain("t2", 40, 15);
`ifdef ARB_STATS_EN
      cycle();
      check("t2_pkt_cnt", 64'(pkt_cnt), 64'd5);
      check("t2_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

      // 3: downstream full for 4 cycles mid-packet, then empty gaps
      load_pkt(2, 4);
      cycle();
      cycle();
      check("t3_head_sent", 64'(sb.size()), 64'd3);
      full_r = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("t3_full_push", 64'(push_o), 64'd0);
         check("t3_full_grant", 64'(grant_o), 64'b00100);
      end
      full_r = 1'b0;
      drain("t3_full", 10, 3);
      load_pkt(2, 3);
      cycle();
      cycle();
      hide[2] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         check("t3_empty_push", 64'(push_o), 64'd0);
         check("t3_empty_busy", 64'(busy_o), 64'd1);
      end
      hide[2] = 1'b0;
      drain("t3_empty", 10, 2);
`ifdef ARB_STATS_EN
      cycle();
      check("t3_pkt_cnt", 64'(pkt_cnt), 64'd7);
      check("t3_stall_cnt", 64'(stall_cnt), 64'd6);
`endif

      // 4: singles; move ptr to 4, then in4 must beat in3, then wrap
      load_pkt(3, 1);
      drain("t4_setup", 10, 2);
      load_pkt(4, 1);
      load_pkt(3, 1);
      drain("t4_pair", 10, 4);
      load_pkt(4, 1);
      load_pkt(0, 1);
      drain("t4_wrap", 10, 4);

      // 5: BODY at front of in1 is never granted or popped
      inq[1].push_back({FLIT_TYPE_BODY, 30'h1234});
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t5_grant", 64'(grant_o), 64'd0);
         check("t5_pop", 64'(pop_o), 64'd0);
      end
      load_pkt(3, 1);
      drain("t5_other", 10, 2);
      check("t5_body_kept", 64'(inq[1].size()), 64'd1);
      inq[1].delete();

      // 6: reset in the middle of a packet
      load_pkt(0, 4);
      cycle();
      cycle();
      rst_r = 1'b1;
      cycle();
      check("t6_rst_push", 64'(push_o), 64'd0);
      check("t6_rst_pop", 64'(pop_o), 64'd0);
      rst_r = 1'b0;
      sb.delete();
      cycle();
      check("t6_grant", 64'(grant_o), 64'd0);
      check("t6_busy", 64'(busy_o), 64'd0);
      check("t6_push", 64'(push_o), 64'd0);
`ifdef ARB_STATS_EN
      check("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
      check("t6_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      inq[0].delete();
      cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
